// File: rtl/pool_window_gen.sv
// pool_window_gen
// Turns a raster-order pixel stream into non-overlapping 2x2 windows
// (stride 2) for a downstream maxpool stage.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous active-high reset
//   in_valid    in_pixel is valid this cycle
//   in_sof      start of frame, qualified by in_valid
//   in_pixel    raster-order pixel, DATA_W bits
//   win_valid   one-cycle pulse, pixel1..pixel4 hold a new window
//   pixel1..4   top-left, top-right, bottom-left, bottom-right
//   frame_done  one-cycle pulse with the last window of a frame
//
// Even rows are stored in a one-line buffer. On odd rows the even-column
// pixel is parked in a holding register, and the odd-column pixel closes
// the window.
module pool_window_gen #(
    parameter int DATA_W = 4,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              win_valid,
    output logic [DATA_W-1:0] pixel1,
    output logic [DATA_W-1:0] pixel2,
    output logic [DATA_W-1:0] pixel3,
    output logic [DATA_W-1:0] pixel4,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] bot_left;
    logic [DATA_W-1:0] line_buf [IMG_W];

    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_row;
    logic [CW-1:0] left_col;
    logic          col_last;
    logic          row_last;
    logic          odd_row;
    logic          odd_col;
    logic          win_fire;

    // A start-of-frame pixel is position (0,0) no matter where the counters
    // are, so every decision below uses the effective position.
    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        col_last = (cur_col == CW'(IMG_W - 1));
        row_last = (cur_row == RW'(IMG_H - 1));
        nxt_col  = col_last ? '0 : cur_col + CW'(1);
        nxt_row  = cur_row;
        if (col_last) begin
            nxt_row = row_last ? '0 : cur_row + RW'(1);
        end
        odd_row  = cur_row[0];
        odd_col  = cur_col[0];
        left_col = cur_col & ~CW'(1);
        win_fire = in_valid & odd_row & odd_col;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            bot_left   <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            pixel1     <= '0;
            pixel2     <= '0;
            pixel3     <= '0;
            pixel4     <= '0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                col <= nxt_col;
                row <= nxt_row;
                if (odd_row && !odd_col) begin
                    bot_left <= in_pixel;
                end
                if (win_fire) begin
                    pixel1     <= line_buf[left_col];
                    pixel2     <= line_buf[cur_col];
                    pixel3     <= bot_left;
                    pixel4     <= in_pixel;
                    win_valid  <= 1'b1;
                    frame_done <= row_last & col_last;
                end
            end
        end
    end

    // Line buffer is not reset: an entry is always rewritten on the even
    // row before the following odd row can read it.
    always_ff @(posedge clk) begin
        if (in_valid && !odd_row) begin
            line_buf[cur_col] <= in_pixel;
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
module tb_pool_window_gen;
    localparam int DW = 4;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          win_valid;
    logic          frame_done;
    logic [DW-1:0] pixel1, pixel2, pixel3, pixel4;

    always #5 clk = ~clk;

    pool_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .win_valid(win_valid),
        .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3), .pixel4(pixel4),
        .frame_done(frame_done)
    );

    int tests = 0;
    int fails = 0;
    int fd_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a 2-D frame image indexed by raster position.
    logic [DW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;
    logic          e_wv = 1'b0;
    logic          e_fd = 1'b0;
    logic [DW-1:0] e_p1 = '0, e_p2 = '0, e_p3 = '0, e_p4 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mr = 0; mc = 0;
            e_wv = 1'b0; e_fd = 1'b0;
            e_p1 = '0; e_p2 = '0; e_p3 = '0; e_p4 = '0;
        end else begin
            e_wv = 1'b0;
            e_fd = 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    mr = 0; mc = 0;
                end
                img[mr][mc] = in_pixel;
                if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                    e_p1 = img[mr-1][mc-1];
                    e_p2 = img[mr-1][mc];
                    e_p3 = img[mr][mc-1];
                    e_p4 = in_pixel;
                    e_wv = 1'b1;
                    e_fd = (mr == H - 1) && (mc == W - 1);
                end
                mc = mc + 1;
                if (mc == W) begin
                    mc = 0;
                    mr = (mr + 1) % H;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("win_valid", win_valid, e_wv);
        chk("frame_done", frame_done, e_fd);
        chk("pixel1", pixel1, e_p1);
        chk("pixel2", pixel2, e_p2);
        chk("pixel3", pixel3, e_p3);
        chk("pixel4", pixel4, e_p4);
        if (frame_done === 1'b1) fd_count++;
    end

    task automatic send(input logic [DW-1:0] p, input logic sof);
        @(negedge clk); #1;
        rst = 1'b0; in_valid = 1'b1; in_sof = sof; in_pixel = p;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            in_valid = 1'b0; in_sof = 1'b0; in_pixel = DW'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input int base, input logic first_sof);
        for (int i = 0; i < W * H; i++) begin
            send(DW'(base + i), (i == 0) ? first_sof : 1'b0);
        end
    endtask

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Literal window expectation, checked on both the DUT and the model.
    task automatic chk_win(input string name, input int a, input int b, input int c,
                           input int d, input logic fd);
        chk({name, "_wv"}, win_valid, 1);
        chk({name, "_fd"}, frame_done, fd);
        chk({name, "_p"}, {pixel1, pixel2, pixel3, pixel4},
            {DW'(a), DW'(b), DW'(c), DW'(d)});
        chk({name, "_model"}, {e_p1, e_p2, e_p3, e_p4}, {DW'(a), DW'(b), DW'(c), DW'(d)});
        chk({name, "_max"}, max4(pixel1, pixel2, pixel3, pixel4), max4(a, b, c, d));
    endtask

    task automatic chk_held(input string name, input int a, input int b, input int c, input int d);
        chk({name, "_wv"}, win_valid, 0);
        chk({name, "_p"}, {pixel1, pixel2, pixel3, pixel4},
            {DW'(a), DW'(b), DW'(c), DW'(d)});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", {win_valid, frame_done, pixel1, pixel2, pixel3, pixel4}, 0);

        // Basic stream
        send(1, 1'b1); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
        send(6, 1'b0);
        chk_win("basic_w0", 1, 2, 5, 6, 1'b0);
        chk("basic_max0", max4(pixel1, pixel2, pixel3, pixel4), 6);
        send(7, 1'b0);
        chk_held("basic_hold", 1, 2, 5, 6);
        send(8, 1'b0);
        chk_win("basic_w1", 3, 4, 7, 8, 1'b1);
        chk("basic_max1", max4(pixel1, pixel2, pixel3, pixel4), 8);
        idle(2);
        chk_held("basic_idle", 3, 4, 7, 8);

        // Gap of three idle cycles between pixels 5 and 6
        send(1, 1'b1); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk_held("gap_hold", 3, 4, 7, 8);
        end
        send(6, 1'b0);
        chk_win("gap_w0", 1, 2, 5, 6, 1'b0);
        send(7, 1'b0); send(8, 1'b0);
        chk_win("gap_w1", 3, 4, 7, 8, 1'b1);
        idle(1);

        // Two back-to-back frames; the second relies on counter wrap
        fd_count = 0;
        send_frame(1, 1'b1);
        for (int i = 0; i < W * H; i++) begin
            send(DW'(9 + i), 1'b0);
            if (i == 5) chk_win("b2b_w0", 9, 10, 13, 14, 1'b0);
        end
        chk_win("b2b_w1", 11, 12, 15, 0, 1'b1);
        idle(2);
        chk("b2b_fd_count", fd_count, 2);

        // Reset mid-frame, then a full frame without in_sof
        send(1, 1'b1); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_out", {win_valid, frame_done, pixel1, pixel2, pixel3, pixel4}, 0);
        send_frame(1, 1'b0);
        chk_win("rst_w1", 3, 4, 7, 8, 1'b1);
        chk("rst_model_pin", {e_p1, e_p2, e_p3, e_p4}, {4'd3, 4'd4, 4'd7, 4'd8});

        // in_sof restarts a partial frame
        idle(1);
        send(1, 1'b1); send(2, 1'b0); send(3, 1'b0);
        for (int i = 0; i < W * H; i++) begin
            send(DW'(1 + i), (i == 0));
            if (i == 5) chk_win("sof_w0", 1, 2, 5, 6, 1'b0);
        end
        chk_win("sof_w1", 3, 4, 7, 8, 1'b1);

        // in_sof without in_valid is ignored
        idle(1);
        send(1, 1'b1); send(2, 1'b0); send(3, 1'b0); send(4, 1'b0); send(5, 1'b0);
        @(negedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b1;
        @(posedge clk); #1;
        send(6, 1'b0);
        chk_win("sofnv_w0", 1, 2, 5, 6, 1'b0);
        idle(1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            rst      = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_sof   = ($urandom_range(0, 24) == 0);
            in_pixel = DW'($urandom);
        end
        @(negedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pool_window_gen.md
POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 Parameter DATA_W, default 4: pixel bit width, matching the maxpool pixel inputs.
REQ-002 Parameter IMG_W, default 8: pixels per line; shall be even and at least 2.
REQ-003 Parameter IMG_H, default 8: lines per frame; shall be even and at least 2.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: asynchronous, active-high reset.
REQ-006 in_valid  input  1: in_pixel is valid this cycle.
REQ-007 in_sof  input  1: start of frame; qualified by in_valid.
REQ-008 in_pixel  input  DATA_W: raster-order pixel (row-major, left to right, top to bottom).
REQ-009 win_valid  output  1: one-cycle pulse; pixel1..pixel4 hold a new 2x2 window.
REQ-010 pixel1  output  DATA_W: window top-left.
REQ-011 pixel2  output  DATA_W: window top-right.
REQ-012 pixel3  output  DATA_W: window bottom-left.
REQ-013 pixel4  output  DATA_W: window bottom-right.
REQ-014 frame_done  output  1: one-cycle pulse, coincident with win_valid for the last window of a frame.

Function
REQ-015 The block shall keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1), both advancing only on cycles with in_valid=1.
REQ-016 The column counter shall wrap from IMG_W-1 to 0 and increment the row counter; the row counter shall wrap from IMG_H-1 to 0.
REQ-017 Cycles with in_valid=0 shall leave all counters, buffers and outputs unchanged, except that win_valid and frame_done are 0.
REQ-018 An accepted pixel on an even row shall be written to a line buffer of IMG_W entries at the current column address.
REQ-019 An accepted pixel on an odd row at an even column shall be captured into a bottom-left holding register.
REQ-020 An accepted pixel on an odd row at an odd column c shall form a window: pixel1=linebuf[c-1], pixel2=linebuf[c], pixel3=held bottom-left, pixel4=in_pixel.
REQ-021 The window outputs shall be registered; win_valid shall assert exactly 1 cycle after the accepting edge of the bottom-right pixel.
REQ-022 pixel1..pixel4 shall hold their last window value until the next window; they are not cleared when win_valid deasserts.
REQ-023 The block shall produce exactly (IMG_W/2)*(IMG_H/2) windows per frame, non-overlapping (stride 2).
REQ-024 frame_done shall assert with the window whose bottom-right pixel is at row IMG_H-1, column IMG_W-1.
REQ-025 in_sof=1 with in_valid=1 shall treat that pixel as row 0, column 0 regardless of counter state, discarding any partial frame; a pending bottom-left value shall not be used.
REQ-026 in_sof without in_valid shall be ignored.
REQ-027 There is no backpressure; the downstream maxpool stage shall accept every win_valid pulse.
REQ-028 Arithmetic is pass-through only; pixel values shall be forwarded bit-exact with no width change.

Reset
REQ-029 While rst=1: counters=0, bottom-left register=0, win_valid=0, frame_done=0, pixel1..pixel4=0.
REQ-030 Line buffer contents need not be reset, but shall never reach an output before being rewritten in the current frame.
REQ-031 Reset asserted mid-frame shall abandon that frame; the first in_valid pixel after release shall be row 0, column 0.

Verification
REQ-032 IMG_W=4, IMG_H=2, rows {1,2,3,4},{5,6,7,8} with continuous in_valid -> win_valid after pixel 6 with (1,2,5,6); after pixel 8 with (3,4,7,8) and frame_done=1.
REQ-033 Same stream with in_valid deasserted for 3 cycles between pixels 5 and 6 -> identical windows; no win_valid during the gap; outputs held.
REQ-034 Two back-to-back frames, second frame rows {9,10,11,12},{13,14,15,0} -> windows (9,10,13,14) and (11,12,15,0); frame_done once per frame.
REQ-035 rst pulsed after pixel 5, then the full 8-pixel frame sent -> all outputs 0 during reset; windows (1,2,5,6) and (3,4,7,8) afterward.
REQ-036 in_sof asserted with value 1 after pixels 1..3 of a frame, then the full 8-pixel frame -> windows (1,2,5,6) and (3,4,7,8); no window from the partial frame.
REQ-037 Windows fed into maxpool -> maximum values 6 and 8 for the REQ-032 stream.
